cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 98 +++++++++
 tb/tb_cache_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one memory port; dcache wins ties up to DSTREAK_MAX times in a row.
// Latency: grant one cycle after an IDLE request, response passed through in the mem_resp cycle. There is no backpressure: requests hold their level until the response.
module cache_mem_arbiter #(
  parameter int DSTREAK_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  localparam int SW = (DSTREAK_MAX < 4) ? 2 : $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] DMAX = SW'(DSTREAK_MAX);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          d_req;

  assign d_req = d_read | d_write;

  // Every grant returns to IDLE, which gives the one-cycle bubble after each completion.
  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_read || dstreak_q < DMAX)) begin
          state_d = GRANT_D;
          if (!i_read)
            dstreak_d = '0;
          else if (dstreak_q != {SW{1'b1}})
            dstreak_d = dstreak_q + 1'b1;
        end else if (i_read) begin
          state_d   = GRANT_I;
          dstreak_d = '0;
        end
      end
      GRANT_I: if (mem_resp || !i_read) state_d = IDLE;
      GRANT_D: if (mem_resp || !d_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  // Grant-state forwarding is combinational from the live requester inputs.
  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      GRANT_I: begin
        mem_addr = i_addr;
        mem_read = i_read;
        i_resp   = mem_resp;
      end
      GRANT_D: begin
        mem_addr  = d_addr;
        mem_read  = d_read;
        mem_write = d_write;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios, then randomized requesters and memory.
// Checked against a transaction-level model of who owns the memory port.
module tb_cache_mem_arbiter;
  localparam int DMAX = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic         mem_read, mem_write, mem_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  cache_mem_arbiter #(.DSTREAK_MAX(DMAX)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // Port owner: 0 = nobody, 1 = icache, 2 = dcache; streak = dcache wins while icache waits.
  int m_own = 0;
  int m_streak = 0;
  logic e_iresp, e_dresp;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model mid-cycle.
  task automatic at_neg();
    logic [31:0]  e_addr;
    logic         e_rd, e_wr;
    logic [255:0] e_wd;
    @(negedge clk);
    assert (!(d_read && d_write)) else $error("protocol: d_read and d_write both high");
    e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0; e_iresp = 1'b0; e_dresp = 1'b0;
    if (m_own == 1) begin
      e_addr = i_addr; e_rd = i_read; e_iresp = mem_resp;
    end else if (m_own == 2) begin
      e_addr = d_addr; e_rd = d_read; e_wr = d_write; e_wd = d_wdata; e_dresp = mem_resp;
    end
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_read", mem_read, e_rd);
    chk("m_mem_write", mem_write, e_wr);
    chk("m_mem_wdata", mem_wdata, e_wd);
    chk("m_i_resp", i_resp, e_iresp);
    chk("m_d_resp", d_resp, e_dresp);
    chk("m_i_rdata", i_rdata, mem_rdata);
    chk("m_d_rdata", d_rdata, mem_rdata);
  endtask

  // Advance the model at the clock edge using the inputs held across it.
  task automatic adv();
    bit ireq, dreq;
    @(posedge clk);
    ireq = i_read;
    dreq = d_read || d_write;
    if (rst) begin
      m_own = 0; m_streak = 0;
    end else if (m_own == 0) begin
      if (ireq && dreq) begin
        if (m_streak < DMAX) begin
          m_own = 2; m_streak = (m_streak + 1 > 3) ? 3 : m_streak + 1;
        end else begin
          m_own = 1; m_streak = 0;
        end
      end else if (ireq) begin
        m_own = 1; m_streak = 0;
      end else if (dreq) begin
        m_own = 2; m_streak = 0;
      end
    end else if (mem_resp || (m_own == 1 && !ireq) || (m_own == 2 && !dreq)) begin
      m_own = 0;
    end
    #1;
  endtask

  initial begin
    bit i_act, d_act, d_wr;
    int lat;
    rst = 1'b1; i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    adv();
    rst = 1'b0;

    // Lone icache read, memory answers 5 cycles after the request.
    i_read = 1'b1; i_addr = 32'h0000_1020;
    at_neg(); adv();
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("li_wait_read", mem_read, 1'b1);
      adv();
    end
    mem_resp = 1'b1; mem_rdata = {8{32'hA5A5_0001}};
    at_neg();
    chk("li_mem_addr", mem_addr, 32'h0000_1020);
    chk("li_mem_read", mem_read, 1'b1);
    chk("li_i_resp", i_resp, 1'b1);
    chk("li_i_rdata", i_rdata, {8{32'hA5A5_0001}});
    chk("li_d_resp", d_resp, 1'b0);
    adv();
    mem_resp = 1'b0;
    at_neg();
    chk("li_bubble_read", mem_read, 1'b0);
    chk("li_bubble_resp", i_resp, 1'b0);
    i_read = 1'b0;
    adv();

    // Simultaneous requests: dcache first, icache after the bubble.
    i_read = 1'b1; i_addr = 32'h0000_2000; d_read = 1'b1; d_addr = 32'h0000_3000;
    at_neg(); adv();
    mem_resp = 1'b1;
    at_neg();
    chk("sim_d_first_addr", mem_addr, 32'h0000_3000);
    chk("sim_d_resp", d_resp, 1'b1);
    chk("sim_i_noresp", i_resp, 1'b0);
    adv();
    mem_resp = 1'b0; d_read = 1'b0;
    at_neg();
    chk("sim_bubble", mem_read, 1'b0);
    adv();
    mem_resp = 1'b1;
    at_neg();
    chk("sim_i_addr", mem_addr, 32'h0000_2000);
    chk("sim_i_resp", i_resp, 1'b1);
    chk("sim_d_noresp", d_resp, 1'b0);
    adv();
    mem_resp = 1'b0;

    // Starvation: icache held, dcache requesting every IDLE -> D,D,D,I.
    d_read = 1'b1;
    for (int g = 0; g < 4; g++) begin
      mem_resp = 1'b0;
      at_neg(); adv();
      mem_resp = 1'b1;
      at_neg();
      chk($sformatf("starve_d_resp_%0d", g), d_resp, (g < 3) ? 1'b1 : 1'b0);
      chk($sformatf("starve_i_resp_%0d", g), i_resp, (g == 3) ? 1'b1 : 1'b0);
      adv();
    end
    i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
    at_neg(); adv();

    // Writeback, then a fill at a new address as its own transaction.
    d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = {8{32'hDEAD_BEEF}};
    at_neg(); adv();
    mem_resp = 1'b1;
    at_neg();
    chk("wb_mem_write", mem_write, 1'b1);
    chk("wb_mem_read", mem_read, 1'b0);
    chk("wb_mem_wdata", mem_wdata, {8{32'hDEAD_BEEF}});
    chk("wb_mem_addr", mem_addr, 32'h8000_0040);
    chk("wb_d_resp", d_resp, 1'b1);
    adv();
    mem_resp = 1'b0; d_write = 1'b0; d_read = 1'b1; d_addr = 32'h8000_0080;
    at_neg();
    chk("wb_bubble_write", mem_write, 1'b0);
    chk("wb_bubble_resp", d_resp, 1'b0);
    adv();
    mem_resp = 1'b1;
    at_neg();
    chk("fill_mem_addr", mem_addr, 32'h8000_0080);
    chk("fill_mem_read", mem_read, 1'b1);
    chk("fill_d_resp", d_resp, 1'b1);
    adv();
    mem_resp = 1'b0; d_read = 1'b0;
    at_neg(); adv();

    // Reset in the middle of a dcache writeback.
    d_write = 1'b1;
    at_neg(); adv();
    at_neg();
    chk("rmid_granted", mem_write, 1'b1);
    adv();
    rst = 1'b1;
    at_neg(); adv();
    rst = 1'b0;
    at_neg();
    chk("rmid_mem_write", mem_write, 1'b0);
    chk("rmid_d_resp", d_resp, 1'b0);
    d_write = 1'b0;
    adv();

    // Stray memory response while idle.
    mem_resp = 1'b1;
    at_neg();
    chk("stray_i_resp", i_resp, 1'b0);
    chk("stray_d_resp", d_resp, 1'b0);
    adv();
    mem_resp = 1'b0;
    at_neg();
    chk("stray_still_idle", mem_addr, 32'h0);
    adv();

    // Randomized requesters and memory with variable latency.
    i_act = 1'b0; d_act = 1'b0; d_wr = 1'b0; lat = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
      end else if (i_act && m_own == 1 && $urandom_range(0, 29) == 0) begin
        i_act = 1'b0;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1; d_wr = $urandom_range(0, 1) == 1; d_addr = $urandom & 32'hFFFF_FFE0;
        for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
      end else if (d_act && m_own == 2 && $urandom_range(0, 29) == 0) begin
        d_act = 1'b0;
      end
      i_read = i_act;
      d_read = d_act && !d_wr;
      d_write = d_act && d_wr;
      for (int k = 0; k < 8; k++) mem_rdata[k*32 +: 32] = $urandom;
      if (m_own != 0) begin
        if (lat == 0) mem_resp = 1'b1;
        else begin
          mem_resp = 1'b0; lat--;
        end
      end else begin
        mem_resp = ($urandom_range(0, 9) == 0);
        lat = $urandom_range(0, 4);
      end
      at_neg(); adv();
      if (e_iresp) i_act = 1'b0;
      if (e_dresp) d_act = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
